collision_detector: RTL and testbench
=====================================

Name: collision_detector

Overview:
- Downstream consumer of the per-pixel object values (player 0/1, missile 0/1, ball, playfield) that the peripherals block produces for color priority.
- Latches every pairwise overlap into sticky collision flags, captures the screen position of the first overlap since the last clear, and counts overlapping pixels per frame.
- Results are exposed through a small read port that the peripherals register decode muxes onto data_out.

Parameters:
- CNT_W, 8, width of the per-frame overlap-pixel counter; saturates at all-ones.
- POS_W, 10, width of hpos/vpos.

Ports:
- clk  in  1  pixel-rate clock; same clock that advances hpos/vpos.
- reset  in  1  asynchronous, active-low reset.
- player_0_value  in  1  object value for the current pixel.
- player_1_value  in  1  object value for the current pixel.
- missile_0_value  in  1  object value for the current pixel.
- missile_1_value  in  1  object value for the current pixel.
- ball_value  in  1  object value for the current pixel.
- playfield_value  in  1  object value for the current pixel.
- in_image  in  1  qualifies the current pixel as visible.
- hpos  in  POS_W  current pixel column.
- vpos  in  POS_W  current pixel row.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- clear  in  1  one-cycle strobe; clears flags and the first-hit capture.
- rd_addr  in  3  read register select.
- rd_data  out  8  registered read data.
- collision_any  out  1  OR of all 15 flags, registered.

Behaviour:
- Object index: P0=0, P1=1, M0=2, M1=3, BL=4, PF=5. The 15 pairs are ordered lexicographically:
  - bit0 P0P1, bit1 P0M0, bit2 P0M1, bit3 P0BL, bit4 P0PF
  - bit5 P1M0, bit6 P1M1, bit7 P1BL, bit8 P1PF
  - bit9 M0M1, bit10 M0BL, bit11 M0PF
  - bit12 M1BL, bit13 M1PF, bit14 BLPF
- Stage 1 (S1): register the six values ANDed with in_image, plus hpos and vpos.
- Stage 2 (S2): hit[14:0] = pairwise AND of the S1 values. flags <= flags | hit.
- Latency: an overlap at cycle N is visible in flags, collision_any and the capture registers at N+2. rd_data adds one more cycle, so an overlap is readable at N+3.
- First-hit capture:
  - When first_valid==0 and hit!=0: first_h <= S1 hpos, first_v <= S1 vpos, first_valid <= 1.
  - Later hits leave the capture unchanged until the next clear.
- Overlap counter: increments by 1 for each S2 cycle with hit!=0, saturating at 2^CNT_W-1.
  - frame_start copies the counter into last_count, then zeroes it.
  - If frame_start coincides with a hit: last_count takes the pre-increment value and the counter becomes 1.
- clear:
  - flags <= hit (the clear-cycle hit survives; set wins over clear).
  - first_valid <= (hit!=0), with the capture loaded from the clear-cycle hit if there is one.
  - The counters are not affected by clear.
- Read map (rd_data registered every cycle):
  - 0: flags[7:0]
  - 1: {collision_any, flags[14:8]}
  - 2: first_h[7:0]
  - 3: {first_valid, 5'b0, first_h[9:8]}
  - 4: first_v[7:0]
  - 5: {6'b0, first_v[9:8]}
  - 6: last_count
  - 7: 8'h00
- Reset (reset low, asynchronous): all of the following go to 0, and the S1 pipeline is zeroed:
  - flags, first_h, first_v, first_valid
  - counter, last_count
  - rd_data, collision_any
- Reset asserted mid-frame discards any in-flight pixel pair.
- No wrap on hpos/vpos arithmetic; values are captured verbatim.
- Pixels outside in_image never set flags.

Decomposition:
- Shared package holds:
  - object index constants OBJ_P0..OBJ_PF
  - pair bit constants CX_P0P1..CX_BLPF
  - read address constants CXR_LO, CXR_HI, CXR_FH_LO, CXR_FH_HI, CXR_FV_LO, CXR_FV_HI, CXR_COUNT
- One sub-module is natural: collision_pairs, the purely combinational 6-to-15 pair AND matrix, reused by any future debug overlay.

Test Plan:
- Reset low mid-operation with flags=15'h7FFF, then release → all reads return 0 and collision_any=0 on the first cycle after release.
- P0 and PF high for one in_image pixel at hpos=100, vpos=50:
  - flags=15'h0010 at N+2
  - rd_addr=0 → 8'h10 and rd_addr=1 → 8'h80 (collision_any) at N+3
  - first_h=100, first_v=50, first_valid=1
- Same overlap with in_image=0 → flags stay 0, counter unchanged.
- M1+BL overlap at (20,30), then P0+P1 at (40,60), both before clear → flags=15'h1001 and first_h/first_v stay (20,30).
- Clear in the same S2 cycle as an M0+M1 hit, with prior flags=15'h00FF → flags=15'h0200 and first_valid=1 at the new position.
- 300 overlapping pixels in a frame, then frame_start → rd_addr=6 returns 8'hFF (saturated). Next frame with 3 overlaps → returns 8'h03.

Source files
------------

// File: rtl/collision_detector_pkg.sv
// Shared constants for the collision detector: object indices,
// pair bit positions in the flag vector and read-port register addresses.
package collision_detector_pkg;

    localparam int NUM_OBJ  = 6;
    localparam int NUM_PAIR = 15;

    // Object index within the per-pixel object vector
    localparam int OBJ_P0 = 0;
    localparam int OBJ_P1 = 1;
    localparam int OBJ_M0 = 2;
    localparam int OBJ_M1 = 3;
    localparam int OBJ_BL = 4;
    localparam int OBJ_PF = 5;

    // Pair bit positions, lexicographic over object indices
    localparam int CX_P0P1 = 0;
    localparam int CX_P0M0 = 1;
    localparam int CX_P0M1 = 2;
    localparam int CX_P0BL = 3;
    localparam int CX_P0PF = 4;
    localparam int CX_P1M0 = 5;
    localparam int CX_P1M1 = 6;
    localparam int CX_P1BL = 7;
    localparam int CX_P1PF = 8;
    localparam int CX_M0M1 = 9;
    localparam int CX_M0BL = 10;
    localparam int CX_M0PF = 11;
    localparam int CX_M1BL = 12;
    localparam int CX_M1PF = 13;
    localparam int CX_BLPF = 14;

    // Read-port register map
    localparam logic [2:0] CXR_LO    = 3'd0;
    localparam logic [2:0] CXR_HI    = 3'd1;
    localparam logic [2:0] CXR_FH_LO = 3'd2;
    localparam logic [2:0] CXR_FH_HI = 3'd3;
    localparam logic [2:0] CXR_FV_LO = 3'd4;
    localparam logic [2:0] CXR_FV_HI = 3'd5;
    localparam logic [2:0] CXR_COUNT = 3'd6;

endpackage

// File: rtl/collision_detector_if.sv
// Read port of the collision detector.
// rd_addr: register select (from decoder); rd_data: registered read data.
interface collision_detector_if;

    logic [2:0] rd_addr;
    logic [7:0] rd_data;

    modport master (
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/collision_detector_pairs.sv
// Combinational 6-object to 15-pair overlap matrix.
// i_obj: object values indexed by OBJ_*; o_hit: pair ANDs indexed by CX_*.
module collision_pairs
    import collision_detector_pkg::*;
(
    input  logic [NUM_OBJ-1:0]  i_obj,
    output logic [NUM_PAIR-1:0] o_hit
);

    assign o_hit[CX_P0P1] = i_obj[OBJ_P0] & i_obj[OBJ_P1];
    assign o_hit[CX_P0M0] = i_obj[OBJ_P0] & i_obj[OBJ_M0];
    assign o_hit[CX_P0M1] = i_obj[OBJ_P0] & i_obj[OBJ_M1];
    assign o_hit[CX_P0BL] = i_obj[OBJ_P0] & i_obj[OBJ_BL];
    assign o_hit[CX_P0PF] = i_obj[OBJ_P0] & i_obj[OBJ_PF];
    assign o_hit[CX_P1M0] = i_obj[OBJ_P1] & i_obj[OBJ_M0];
    assign o_hit[CX_P1M1] = i_obj[OBJ_P1] & i_obj[OBJ_M1];
    assign o_hit[CX_P1BL] = i_obj[OBJ_P1] & i_obj[OBJ_BL];
    assign o_hit[CX_P1PF] = i_obj[OBJ_P1] & i_obj[OBJ_PF];
    assign o_hit[CX_M0M1] = i_obj[OBJ_M0] & i_obj[OBJ_M1];
    assign o_hit[CX_M0BL] = i_obj[OBJ_M0] & i_obj[OBJ_BL];
    assign o_hit[CX_M0PF] = i_obj[OBJ_M0] & i_obj[OBJ_PF];
    assign o_hit[CX_M1BL] = i_obj[OBJ_M1] & i_obj[OBJ_BL];
    assign o_hit[CX_M1PF] = i_obj[OBJ_M1] & i_obj[OBJ_PF];
    assign o_hit[CX_BLPF] = i_obj[OBJ_BL] & i_obj[OBJ_PF];

endmodule

// File: rtl/collision_detector.sv
// Sticky pairwise collision flags, first-hit position capture and a
// per-frame overlap-pixel counter, exposed through a registered read port.
// Ports: clk, reset (async, active-low), six object values, in_image,
// hpos/vpos, frame_start, clear, rd (read interface), collision_any.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int POS_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             player_0_value,
    input  logic             player_1_value,
    input  logic             missile_0_value,
    input  logic             missile_1_value,
    input  logic             ball_value,
    input  logic             playfield_value,
    input  logic             in_image,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic             frame_start,
    input  logic             clear,
    collision_detector_if.slave rd,
    output logic             collision_any
);

    logic [NUM_OBJ-1:0]  w_obj;
    logic [NUM_OBJ-1:0]  r_s1_obj;
    logic [POS_W-1:0]    r_s1_h;
    logic [POS_W-1:0]    r_s1_v;

    logic [NUM_PAIR-1:0] w_hit;
    logic                w_any_hit;

    logic [NUM_PAIR-1:0] r_flags;
    logic [NUM_PAIR-1:0] w_flags_nxt;

    logic                r_first_valid;
    logic [POS_W-1:0]    r_first_h;
    logic [POS_W-1:0]    r_first_v;
    logic                w_first_valid_nxt;
    logic [POS_W-1:0]    w_first_h_nxt;
    logic [POS_W-1:0]    w_first_v_nxt;

    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_last_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [CNT_W-1:0]    w_last_count_nxt;
    logic [CNT_W-1:0]    w_count_inc;

    logic [7:0]          w_rd_nxt;

    // Off-screen pixels are masked here so they can never set a flag.
    always_comb begin
        w_obj         = '0;
        w_obj[OBJ_P0] = player_0_value;
        w_obj[OBJ_P1] = player_1_value;
        w_obj[OBJ_M0] = missile_0_value;
        w_obj[OBJ_M1] = missile_1_value;
        w_obj[OBJ_BL] = ball_value;
        w_obj[OBJ_PF] = playfield_value;
        w_obj         = w_obj & {NUM_OBJ{in_image}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_obj <= '0;
            r_s1_h   <= '0;
            r_s1_v   <= '0;
        end else begin
            r_s1_obj <= w_obj;
            r_s1_h   <= hpos;
            r_s1_v   <= vpos;
        end
    end

    collision_pairs u_pairs (
        .i_obj (r_s1_obj),
        .o_hit (w_hit)
    );

    assign w_any_hit = |w_hit;

    // A hit in the clear cycle survives the clear.
    assign w_flags_nxt = clear ? w_hit : (r_flags | w_hit);

    always_comb begin
        w_first_valid_nxt = r_first_valid;
        w_first_h_nxt     = r_first_h;
        w_first_v_nxt     = r_first_v;
        if (clear) begin
            w_first_valid_nxt = w_any_hit;
            w_first_h_nxt     = w_any_hit ? r_s1_h : '0;
            w_first_v_nxt     = w_any_hit ? r_s1_v : '0;
        end else if (!r_first_valid && w_any_hit) begin
            w_first_valid_nxt = 1'b1;
            w_first_h_nxt     = r_s1_h;
            w_first_v_nxt     = r_s1_v;
        end
    end

    assign w_count_inc = (r_count == '1) ? r_count : (r_count + 1'b1);

    // On frame_start the pre-increment value is reported and a
    // coincident hit becomes the first count of the new frame.
    always_comb begin
        w_count_nxt      = r_count;
        w_last_count_nxt = r_last_count;
        if (frame_start) begin
            w_last_count_nxt = r_count;
            w_count_nxt      = w_any_hit ? CNT_W'(1) : '0;
        end else if (w_any_hit) begin
            w_count_nxt = w_count_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags       <= '0;
            collision_any <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_h     <= '0;
            r_first_v     <= '0;
            r_count       <= '0;
            r_last_count  <= '0;
        end else begin
            r_flags       <= w_flags_nxt;
            collision_any <= |w_flags_nxt;
            r_first_valid <= w_first_valid_nxt;
            r_first_h     <= w_first_h_nxt;
            r_first_v     <= w_first_v_nxt;
            r_count       <= w_count_nxt;
            r_last_count  <= w_last_count_nxt;
        end
    end

    always_comb begin
        w_rd_nxt = 8'h00;
        unique case (rd.rd_addr)
            CXR_LO:    w_rd_nxt = r_flags[7:0];
            CXR_HI:    w_rd_nxt = {collision_any, r_flags[14:8]};
            CXR_FH_LO: w_rd_nxt = r_first_h[7:0];
            CXR_FH_HI: w_rd_nxt = {r_first_valid, 5'b0, r_first_h[9:8]};
            CXR_FV_LO: w_rd_nxt = r_first_v[7:0];
            CXR_FV_HI: w_rd_nxt = {6'b0, r_first_v[9:8]};
            CXR_COUNT: w_rd_nxt = 8'(r_last_count);
            default:   w_rd_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd.rd_data <= 8'h00;
        end else begin
            rd.rd_data <= w_rd_nxt;
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Self-checking bench for collision_detector: table-driven single-pixel
// vectors plus hand-written multi-cycle sequences.
module tb_collision_detector;
    import collision_detector_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0, p1, m0, m1, bl, pf, in_img;
    logic [9:0] hpos, vpos;
    logic       frame_start, clear;
    logic       collision_any;

    collision_detector_if rd();

    collision_detector #(.CNT_W(8), .POS_W(10)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .player_0_value  (p0),
        .player_1_value  (p1),
        .missile_0_value (m0),
        .missile_1_value (m1),
        .ball_value      (bl),
        .playfield_value (pf),
        .in_image        (in_img),
        .hpos            (hpos),
        .vpos            (vpos),
        .frame_start     (frame_start),
        .clear           (clear),
        .rd              (rd),
        .collision_any   (collision_any)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  obj;
        logic        inimg;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [14:0] flags;
        logic        valid;
        logic [9:0]  fh;
        logic [9:0]  fv;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [5:0] o, input logic ii,
                           input logic [9:0] h, input logic [9:0] v);
        p0 = o[0]; p1 = o[1]; m0 = o[2];
        m1 = o[3]; bl = o[4]; pf = o[5];
        in_img = ii;
        hpos = h;
        vpos = v;
    endtask

    task automatic idle();
        set_pix(6'b0, 1'b0, 10'd0, 10'd0);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a,
                          input logic [7:0] e);
        rd.rd_addr = a;
        tick();
        check(nm, rd.rd_data, e);
    endtask

    task automatic do_clear();
        idle();
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic [7:0] exp_rd(input logic [2:0] a,
        input logic [14:0] f, input logic vl,
        input logic [9:0] fh, input logic [9:0] fv);
        logic [7:0] r;
        case (a)
            3'd0: r = f[7:0];
            3'd1: r = {|f, f[14:8]};
            3'd2: r = fh[7:0];
            3'd3: r = {vl, 5'b0, fh[9:8]};
            3'd4: r = fv[7:0];
            3'd5: r = {6'b0, fv[9:8]};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [5:0] two_obj[8];

    initial begin
        // obj bit order: {PF, BL, M1, M0, P1, P0}
        vecs[0] = '{6'b100001, 1'b1, 10'd100, 10'd50,
                    15'h0010, 1'b1, 10'd100, 10'd50, 8'd1};
        vecs[1] = '{6'b100001, 1'b0, 10'd100, 10'd50,
                    15'h0000, 1'b0, 10'd0, 10'd0, 8'd0};
        vecs[2] = '{6'b111111, 1'b1, 10'd1023, 10'd1023,
                    15'h7FFF, 1'b1, 10'd1023, 10'd1023, 8'd1};
        vecs[3] = '{6'b000010, 1'b1, 10'd7, 10'd9,
                    15'h0000, 1'b0, 10'd0, 10'd0, 8'd0};
        vecs[4] = '{6'b011100, 1'b1, 10'd512, 10'd768,
                    15'h1600, 1'b1, 10'd512, 10'd768, 8'd1};
        vecs[5] = '{6'b010010, 1'b1, 10'd5, 10'd6,
                    15'h0080, 1'b1, 10'd5, 10'd6, 8'd1};
        vecs[6] = '{6'b110000, 1'b1, 10'd0, 10'd0,
                    15'h4000, 1'b1, 10'd0, 10'd0, 8'd1};

        two_obj[0] = 6'b000011; two_obj[1] = 6'b000101;
        two_obj[2] = 6'b001001; two_obj[3] = 6'b010001;
        two_obj[4] = 6'b100001; two_obj[5] = 6'b000110;
        two_obj[6] = 6'b001010; two_obj[7] = 6'b010010;

        rst_n = 1'b0;
        clear = 1'b0;
        frame_start = 1'b0;
        rd.rd_addr = 3'd0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-operation with all flags set and a pixel in flight
        set_pix(6'b111111, 1'b1, 10'd1023, 10'd1023);
        tick();
        idle();
        tick();
        rd_chk("pre_rst_lo", 3'd0, 8'hFF);
        rd_chk("pre_rst_hi", 3'd1, 8'hFF);
        set_pix(6'b000011, 1'b1, 10'd3, 10'd4);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_any", collision_any, 1'b0);
        check("rst_rd", rd.rd_data, 8'h00);
        idle();
        tick();
        rst_n = 1'b1;
        check("rel_any", collision_any, 1'b0);
        check("rel_rd", rd.rd_data, 8'h00);
        for (int a = 0; a < 8; a++)
            rd_chk($sformatf("rel_rd%0d", a), 3'(a), 8'h00);
        check("rel_any2", collision_any, 1'b0);

        // Table-driven single-pixel vectors
        for (int i = 0; i < 7; i++) begin
            idle();
            tick();
            tick();
            clear = 1'b1;
            frame_start = 1'b1;
            tick();
            clear = 1'b0;
            frame_start = 1'b0;
            rd.rd_addr = 3'd0;
            set_pix(vecs[i].obj, vecs[i].inimg, vecs[i].h, vecs[i].v);
            tick();
            idle();
            check($sformatf("v%0d_lat_any", i), collision_any, 1'b0);
            tick();
            check($sformatf("v%0d_any", i), collision_any,
                  |vecs[i].flags);
            check($sformatf("v%0d_lat_rd", i), rd.rd_data, 8'h00);
            for (int a = 0; a < 6; a++)
                rd_chk($sformatf("v%0d_rd%0d", i, a), 3'(a),
                       exp_rd(3'(a), vecs[i].flags, vecs[i].valid,
                              vecs[i].fh, vecs[i].fv));
            pulse_frame();
            rd_chk($sformatf("v%0d_cnt", i), 3'd6, vecs[i].cnt);
        end

        // Two overlaps before clear: first position is kept
        do_clear();
        set_pix(6'b011000, 1'b1, 10'd20, 10'd30);
        tick();
        set_pix(6'b000011, 1'b1, 10'd40, 10'd60);
        tick();
        idle();
        tick();
        tick();
        rd_chk("two_lo", 3'd0, 8'h01);
        rd_chk("two_hi", 3'd1, 8'h90);
        rd_chk("two_fh", 3'd2, 8'd20);
        rd_chk("two_fhh", 3'd3, 8'h80);
        rd_chk("two_fv", 3'd4, 8'd30);
        rd_chk("two_fvh", 3'd5, 8'h00);

        // Clear coincident with an M0+M1 hit, prior flags 0x00FF
        do_clear();
        for (int i = 0; i < 8; i++) begin
            set_pix(two_obj[i], 1'b1, 10'(i + 1), 10'd2);
            tick();
        end
        idle();
        tick();
        tick();
        rd_chk("pre_clr_lo", 3'd0, 8'hFF);
        rd_chk("pre_clr_hi", 3'd1, 8'h80);
        set_pix(6'b001100, 1'b1, 10'd77, 10'd88);
        tick();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        rd_chk("clr_lo", 3'd0, 8'h00);
        rd_chk("clr_hi", 3'd1, 8'h82);
        rd_chk("clr_fh", 3'd2, 8'd77);
        rd_chk("clr_fhh", 3'd3, 8'h80);
        rd_chk("clr_fv", 3'd4, 8'd88);

        // Saturation, then a small frame
        idle();
        tick();
        tick();
        pulse_frame();
        for (int i = 0; i < 300; i++) begin
            set_pix(6'b000011, 1'b1, 10'(i), 10'd1);
            tick();
        end
        idle();
        tick();
        tick();
        pulse_frame();
        rd_chk("cnt_sat", 3'd6, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            set_pix(6'b100001, 1'b1, 10'(i), 10'd2);
            tick();
            idle();
            tick();
        end
        tick();
        tick();
        pulse_frame();
        rd_chk("cnt_3", 3'd6, 8'h03);

        // frame_start in the same S2 cycle as the third hit
        set_pix(6'b000011, 1'b1, 10'd1, 10'd1);
        tick();
        tick();
        tick();
        idle();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        rd_chk("cnt_coin", 3'd6, 8'h02);
        pulse_frame();
        rd_chk("cnt_carry", 3'd6, 8'h01);
        rd_chk("rd7", 3'd7, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
